// File: rtl/beef_rf_pkg.sv
// beef_rf_pkg
//   Shared definitions for the BeeF architectural register file.
//   - REG_* : architectural register indices used by the control FSM.
//   - op_dir_e : direction of the in-place increment/decrement port.
package beef_rf_pkg;

  localparam int REG_PC       = 0;
  localparam int REG_CACHEPTR = 1;
  localparam int REG_STACKPTR = 2;
  localparam int REG_HEADPTR  = 3;
  localparam int REG_REGISTER = 4;

  typedef enum logic {
    OP_INC = 1'b0,
    OP_DEC = 1'b1
  } op_dir_e;

endpackage

// File: rtl/beef_rf_addsub.sv
// beef_rf_addsub
//   Combinational add/subtract used by the in-place op port.
//   Ports:
//     a      in  DATA_WIDTH  current register value
//     amt    in  DATA_WIDTH  unsigned amount
//     dec    in  op_dir_e    OP_INC adds, OP_DEC subtracts
//     result out DATA_WIDTH  wrapped or clamped result
//     ovf    out 1           carry/borrow out (wrap) or clamp engaged (saturate)
module beef_rf_addsub
  import beef_rf_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit SATURATE   = 1'b0
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] amt,
  input  op_dir_e               dec,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  ovf
);

  logic [DATA_WIDTH:0] w_sum;

  always_comb begin
    // One extra bit: it holds the carry on add and the borrow on subtract.
    if (dec == OP_DEC) begin
      w_sum = {1'b0, a} - {1'b0, amt};
    end else begin
      w_sum = {1'b0, a} + {1'b0, amt};
    end
    ovf = w_sum[DATA_WIDTH];
    if (SATURATE && w_sum[DATA_WIDTH]) begin
      result = (dec == OP_DEC) ? '0 : '1;
    end else begin
      result = w_sum[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/beef_reg_file.sv
// beef_reg_file
//   BeeF architectural register file: two combinational read ports,
//   one synchronous write port, one in-place inc/dec port, a one-deep
//   shadow bank (snap/restore/swap), zero flag and optional write bypass.
//   Ports:
//     clk, reset            clock; synchronous active-high reset
//     wen_i/wa_i/write_data_i  write port
//     op_en_i/op_addr_i/op_dec_i/op_amt_i  inc/dec port
//     snap_i/restore_i      shadow capture / shadow restore (both = swap)
//     ra0_i/ra1_i -> rd0_o/rd1_o  combinational reads (0 if out of range)
//     rz0_o                 rd0_o == 0
//     regs_o                stored register taps, never bypassed
//     ovf_o                 registered overflow of the previous op
//     err_o                 sticky out-of-range access flag
module beef_reg_file
  import beef_rf_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = $clog2(NUM_REGS),
  parameter bit SATURATE   = 1'b0,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wen_i,
  input  logic [ADDR_WIDTH-1:0]          wa_i,
  input  logic [DATA_WIDTH-1:0]          write_data_i,
  input  logic                           op_en_i,
  input  logic [ADDR_WIDTH-1:0]          op_addr_i,
  input  logic                           op_dec_i,
  input  logic [DATA_WIDTH-1:0]          op_amt_i,
  input  logic                           snap_i,
  input  logic                           restore_i,
  input  logic [ADDR_WIDTH-1:0]          ra0_i,
  input  logic [ADDR_WIDTH-1:0]          ra1_i,
  output logic [DATA_WIDTH-1:0]          rd0_o,
  output logic [DATA_WIDTH-1:0]          rd1_o,
  output logic                           rz0_o,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic                           ovf_o,
  output logic                           err_o
);

  localparam logic [ADDR_WIDTH:0] LP_NUM_REGS = (ADDR_WIDTH+1)'(NUM_REGS);

  logic [DATA_WIDTH-1:0] r_rf     [NUM_REGS];
  logic [DATA_WIDTH-1:0] r_shadow [NUM_REGS];
  logic                  r_ovf;
  logic                  r_err;

  logic [DATA_WIDTH-1:0] w_nxt [NUM_REGS];
  logic [DATA_WIDTH-1:0] w_src [NUM_REGS];
  logic                  w_ovf_nxt;
  logic                  w_err_nxt;
  logic                  w_wa_in, w_op_in;
  logic                  w_wr_ok, w_op_ok;
  logic [DATA_WIDTH-1:0] w_op_cur, w_op_res;
  logic                  w_op_ovf;
  op_dir_e               w_op_dir;

  assign w_wa_in  = ({1'b0, wa_i} < LP_NUM_REGS);
  assign w_op_in  = ({1'b0, op_addr_i} < LP_NUM_REGS);
  assign w_wr_ok  = wen_i && w_wa_in;
  // A write to the same register takes precedence; the op is simply dropped.
  assign w_op_ok  = op_en_i && w_op_in && !(w_wr_ok && (wa_i == op_addr_i));
  assign w_op_dir = op_dir_e'(op_dec_i);

  always_comb begin
    w_op_cur = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (op_addr_i == ADDR_WIDTH'(k)) w_op_cur = r_rf[k];
    end
  end

  beef_rf_addsub #(
    .DATA_WIDTH (DATA_WIDTH),
    .SATURATE   (SATURATE)
  ) u_addsub (
    .a      (w_op_cur),
    .amt    (op_amt_i),
    .dec    (w_op_dir),
    .result (w_op_res),
    .ovf    (w_op_ovf)
  );

  // Next register state; restore overrides both write and op.
  always_comb begin
    w_ovf_nxt = 1'b0;
    w_err_nxt = r_err;
    for (int k = 0; k < NUM_REGS; k++) begin
      w_nxt[k] = r_rf[k];
    end
    if (restore_i) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        w_nxt[k] = r_shadow[k];
      end
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (w_wr_ok && (wa_i == ADDR_WIDTH'(k))) w_nxt[k] = write_data_i;
        if (w_op_ok && (op_addr_i == ADDR_WIDTH'(k))) w_nxt[k] = w_op_res;
      end
      if (w_op_ok) w_ovf_nxt = w_op_ovf;
      if ((wen_i && !w_wa_in) || (op_en_i && !w_op_in)) w_err_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        r_rf[k]     <= '0;
        r_shadow[k] <= '0;
      end
      r_ovf <= 1'b0;
      r_err <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        r_rf[k] <= w_nxt[k];
        // Shadow takes pre-edge values, so snap with restore is a swap.
        if (snap_i) r_shadow[k] <= r_rf[k];
      end
      r_ovf <= w_ovf_nxt;
      r_err <= w_err_nxt;
    end
  end

  // Read source: next value when bypassing (never during reset), else stored.
  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) begin
      w_src[k] = (BYPASS && !reset) ? w_nxt[k] : r_rf[k];
    end
  end

  always_comb begin
    rd0_o = '0;
    rd1_o = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (ra0_i == ADDR_WIDTH'(k)) rd0_o = w_src[k];
      if (ra1_i == ADDR_WIDTH'(k)) rd1_o = w_src[k];
    end
  end

  assign rz0_o = (rd0_o == '0);

  always_comb begin
    regs_o = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      regs_o[k*DATA_WIDTH +: DATA_WIDTH] = r_rf[k];
    end
  end

  assign ovf_o = r_ovf;
  assign err_o = r_err;

endmodule

// File: doc/beef_reg_file.md
Name: beef_reg_file

Overview:
Parametrised successor to the CPU's 8x8 architectural register file (PC, cacheptr, stackptr, headptr, register).
- Combinational reads on two ports; synchronous writes.
- Adds an in-place increment/decrement port for BeeF `+ - > <` ops, with wrap or saturate.
- Adds a one-deep shadow bank (snapshot/restore/swap), zero flag for `[ ]` branching, and optional write bypass.
- Sits between the decode/control FSM and the datapath; the control FSM drives all ports.

Parameters:
- DATA_WIDTH, 8, register width in bits.
- NUM_REGS, 8, number of registers (>=2; need not be a power of 2).
- ADDR_WIDTH, $clog2(NUM_REGS), address width.
- SATURATE, 0, 0 = inc/dec wraps modulo 2^DATA_WIDTH; 1 = clamps at 0 / all-ones.
- BYPASS, 1, 1 = read ports show the value being written this cycle; 0 = read ports show the stored value.

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-high.
- wen_i  in  1  write enable.
- wa_i  in  ADDR_WIDTH  write address.
- write_data_i  in  DATA_WIDTH  write data.
- op_en_i  in  1  inc/dec enable.
- op_addr_i  in  ADDR_WIDTH  inc/dec target register.
- op_dec_i  in  1  0 = add, 1 = subtract.
- op_amt_i  in  DATA_WIDTH  unsigned amount.
- snap_i  in  1  copy all registers into the shadow bank.
- restore_i  in  1  copy the shadow bank into the registers.
- ra0_i, ra1_i  in  ADDR_WIDTH  read addresses.
- rd0_o, rd1_o  out  DATA_WIDTH  read data, combinational.
- rz0_o  out  1  rd0_o == 0, combinational.
- regs_o  out  NUM_REGS*DATA_WIDTH  flat taps; reg k at bits [k*DATA_WIDTH +: DATA_WIDTH]; stored values only, never bypassed.
- ovf_o  out  1  registered; 1 for the cycle after an op that wrapped or clamped.
- err_o  out  1  sticky; set by a write or op to an address >= NUM_REGS.

Behaviour:
- Reset: on posedge clk with reset=1, all registers and all shadow entries = 0, ovf_o = 0, err_o = 0. All other inputs are ignored that cycle; an operation in flight is dropped.
- Priority, highest first: reset > restore_i > {wen_i, op_en_i}.
- restore_i: all registers take the shadow values next cycle. wen_i and op_en_i are dropped that cycle and ovf_o = 0.
- snap_i: shadow captures the pre-edge register values. Combined with restore_i in the same cycle, this is an atomic swap.
- Write: on edge, RF[wa_i] <= write_data_i.
- Op, wrap mode: RF[op_addr_i] <= RF[op_addr_i] ± op_amt_i, computed in DATA_WIDTH+1 bits. Carry or borrow out sets ovf_o next cycle.
- Op, saturate mode: result clamps to all-ones (add) or 0 (sub); ovf_o=1 when the clamp engages.
- op_amt_i = 0: register unchanged, ovf_o = 0.
- Write and op to the same address in the same cycle: write wins, op dropped, ovf_o = 0. Different addresses: both apply.
- Out-of-range address (wa_i or op_addr_i >= NUM_REGS with its enable high): no state change for that access, err_o <= 1. err_o clears only on reset.
- Out-of-range read address: rd*_o = 0.
- Bypass (BYPASS=1): if ra == an address being updated by an accepted write or op this cycle, rd*_o = the next value. This covers restore too (returns the shadow value). Not applied when reset=1.
- Latency: write/op visible on regs_o and non-bypassed reads 1 cycle after the edge; with bypass, visible in the same cycle.
- ovf_o is cleared on every edge that has no overflowing op.

Decomposition:
- Package beef_rf_pkg holds:
  - index localparams REG_PC=0, REG_CACHEPTR=1, REG_STACKPTR=2, REG_HEADPTR=3, REG_REGISTER=4;
  - typedef for the op direction (OP_INC, OP_DEC).
- Sub-module beef_rf_addsub (combinational): inputs a, amt, dec; outputs result and ovf; SATURATE passed as a parameter.
- Bypass mux and next-state logic stay in the top module.

Test Plan:
- Reset, then wen_i=1, wa_i=3, data=0x5A -> next cycle regs_o[3]=0x5A. With ra0_i=3 in the write cycle: rd0_o=0x5A if BYPASS=1, 0x00 if BYPASS=0.
- Wrap mode: reg1=0xFE, op inc amt 3 -> reg1=0x01, ovf_o=1 for one cycle. Then dec amt 1 -> 0x00, ovf_o=0, and rz0_o=1 with ra0_i=1. In SATURATE=1: 0xFE+3 -> 0xFF, ovf_o=1.
- Same cycle: wen_i to reg2=0x10 and op inc reg2 amt 5 -> reg2=0x10, ovf_o=0. Repeat with op to reg4 -> reg2=0x10, reg4 += 5.
- reg0=0x11; snap; write reg0=0x22; restore together with wen_i reg0=0x33 -> reg0=0x11. Snap+restore in one cycle with reg0=0x44, shadow0=0x11 -> reg0=0x11, shadow0=0x44.
- NUM_REGS=5: wen_i with wa_i=6 -> no register changes, err_o=1 and stays 1 until reset. ra0_i=7 -> rd0_o=0.
- Assert reset together with wen_i and op_en_i -> all registers 0, ovf_o=0, err_o=0, shadow 0 (a following restore yields all zeros).
